// File: rtl/pipelined_lookahead_pkg.sv
// Shared constants and configuration checks for the pipelined look-ahead adder.
//
// Contents:
//   MODE_ADD / MODE_SUB   : encodings of the Mode_In select
//   legal_block_width()   : true when the DATA_WIDTH / BLOCK_WIDTH pair is buildable
package pipelined_lookahead_pkg;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // Block width must be 4, 8 or 16 and tile the operand width exactly.
    function automatic bit legal_block_width(input int data_width, input int block_width);
        return ((block_width == 4) || (block_width == 8) || (block_width == 16)) &&
               (data_width > 0) && ((data_width % block_width) == 0);
    endfunction

endpackage

// File: rtl/lookahead_block.sv
// Combinational carry-look-ahead adder slice.
//
// Ports:
//   a, b  [BLOCK_WIDTH-1:0] : operand slices (b already inverted for subtract)
//   cin                     : carry into bit 0 of the slice
//   sum   [BLOCK_WIDTH-1:0] : slice sum
//   cout                    : carry out of the top bit of the slice
module lookahead_block #(
    parameter int BLOCK_WIDTH = 8
) (
    input  logic [BLOCK_WIDTH-1:0] a,
    input  logic [BLOCK_WIDTH-1:0] b,
    input  logic                   cin,
    output logic [BLOCK_WIDTH-1:0] sum,
    output logic                   cout
);

    logic [BLOCK_WIDTH-1:0] gen;
    logic [BLOCK_WIDTH-1:0] prop;
    logic [BLOCK_WIDTH:0]   carry;

    assign gen  = a & b;
    assign prop = a ^ b;

    // Each carry is built as a flat sum of products:
    //   c[i] = g[i-1] | p[i-1]g[i-2] | ... | p[i-1]..p[0]cin
    // so no carry depends on a previously computed carry bit.
    always_comb begin
        logic term;
        logic acc;
        carry    = '0;
        term     = 1'b0;
        acc      = 1'b0;
        carry[0] = cin;
        for (int i = 1; i <= BLOCK_WIDTH; i++) begin
            term = cin;
            for (int k = 0; k < i; k++) begin
                term = term & prop[k];
            end
            acc = term;
            for (int j = 0; j < i; j++) begin
                term = gen[j];
                for (int k = j + 1; k < i; k++) begin
                    term = term & prop[k];
                end
                acc = acc | term;
            end
            carry[i] = acc;
        end
    end

    assign sum  = prop ^ carry[BLOCK_WIDTH-1:0];
    assign cout = carry[BLOCK_WIDTH];

endmodule

// File: rtl/pipelined_lookahead_adder.sv
// Pipelined add/subtract unit: one look-ahead block per pipeline stage.
//
// Ports:
//   Clock_In, Reset_In (sync, active-high)
//   Data_A_In, Data_B_In [DATA_WIDTH-1:0], Carry_In, Mode_In (0 add, 1 sub)
//   Valid_In / Ready_Out       : input handshake
//   Sum_Out, Carry_Out, Overflow_Out, Zero_Out : registered result flags
//   Valid_Out / Ready_In       : output handshake
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high. The whole pipeline moves together on advance = Ready_In | ~Valid_Out;
// Ready_Out is advance, so an input is taken exactly when the pipe shifts and a
// held result stays stable until the consumer takes it.
module pipelined_lookahead_adder
    import pipelined_lookahead_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int BLOCK_WIDTH = 8
) (
    input  logic                  Clock_In,
    input  logic                  Reset_In,
    input  logic [DATA_WIDTH-1:0] Data_A_In,
    input  logic [DATA_WIDTH-1:0] Data_B_In,
    input  logic                  Carry_In,
    input  logic                  Mode_In,
    input  logic                  Valid_In,
    output logic                  Ready_Out,
    output logic [DATA_WIDTH-1:0] Sum_Out,
    output logic                  Carry_Out,
    output logic                  Overflow_Out,
    output logic                  Zero_Out,
    output logic                  Valid_Out,
    input  logic                  Ready_In
);

    localparam int NUM_STAGES = DATA_WIDTH / BLOCK_WIDTH;

    if (!legal_block_width(DATA_WIDTH, BLOCK_WIDTH)) begin : g_bad_cfg
        $error("pipelined_lookahead_adder: illegal DATA_WIDTH/BLOCK_WIDTH combination");
    end

    logic                  advance;
    logic [DATA_WIDTH-1:0] eff_b;
    logic                  eff_cin;

    logic [DATA_WIDTH-1:0] sum_q;
    logic                  cout_q;
    logic                  ovf_q;
    logic                  zero_q;
    logic                  vout_q;

    assign advance   = Ready_In | ~vout_q;
    assign Ready_Out = advance;

    // Subtract is A + ~B + 1; the external carry-in only matters for add.
    assign eff_b   = (Mode_In == MODE_SUB) ? ~Data_B_In : Data_B_In;
    assign eff_cin = (Mode_In == MODE_SUB) ? 1'b1 : Carry_In;

    // Stage k adds slice k. Registers of stage k keep the operand bits still to
    // be added (above slice k), the finished low sum bits and the slice carry.
    // The last stage's registers are the module outputs.
    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
        localparam int IN_W = DATA_WIDTH - k * BLOCK_WIDTH;

        logic [IN_W-1:0]              src_a;
        logic [IN_W-1:0]              src_b;
        logic                         src_cin;
        logic                         src_valid;
        logic [(k+1)*BLOCK_WIDTH-1:0] done_next;
        logic [BLOCK_WIDTH-1:0]       blk_sum;
        logic                         blk_cout;

        lookahead_block #(
            .BLOCK_WIDTH (BLOCK_WIDTH)
        ) u_block (
            .a    (src_a[BLOCK_WIDTH-1:0]),
            .b    (src_b[BLOCK_WIDTH-1:0]),
            .cin  (src_cin),
            .sum  (blk_sum),
            .cout (blk_cout)
        );

        if (k == 0) begin : g_first
            assign src_a     = Data_A_In;
            assign src_b     = eff_b;
            assign src_cin   = eff_cin;
            assign src_valid = Valid_In;
            assign done_next = blk_sum;
        end else begin : g_next
            assign src_a     = g_stage[k-1].g_mid.a_q;
            assign src_b     = g_stage[k-1].g_mid.b_q;
            assign src_cin   = g_stage[k-1].g_mid.c_q;
            assign src_valid = g_stage[k-1].g_mid.v_q;
            assign done_next = {blk_sum, g_stage[k-1].g_mid.s_q};
        end

        if (k < NUM_STAGES - 1) begin : g_mid
            logic [IN_W-BLOCK_WIDTH-1:0]  a_q;
            logic [IN_W-BLOCK_WIDTH-1:0]  b_q;
            logic [(k+1)*BLOCK_WIDTH-1:0] s_q;
            logic                         c_q;
            logic                         v_q;

            always_ff @(posedge Clock_In) begin
                if (Reset_In) begin
                    v_q <= 1'b0;
                end else if (advance) begin
                    v_q <= src_valid;
                end
                if (advance) begin
                    a_q <= src_a[IN_W-1:BLOCK_WIDTH];
                    b_q <= src_b[IN_W-1:BLOCK_WIDTH];
                    s_q <= done_next;
                    c_q <= blk_cout;
                end
            end
        end else begin : g_last
            // Top slice holds the operand MSBs, so the overflow and zero flags
            // are formed here and registered with the sum.
            always_ff @(posedge Clock_In) begin
                if (Reset_In) begin
                    vout_q <= 1'b0;
                    sum_q  <= '0;
                    cout_q <= 1'b0;
                    ovf_q  <= 1'b0;
                    zero_q <= 1'b0;
                end else if (advance) begin
                    vout_q <= src_valid;
                    sum_q  <= done_next;
                    cout_q <= blk_cout;
                    ovf_q  <= (src_a[IN_W-1] == src_b[IN_W-1]) &&
                              (blk_sum[BLOCK_WIDTH-1] != src_a[IN_W-1]);
                    zero_q <= (done_next == '0);
                end
            end
        end
    end

    assign Sum_Out      = sum_q;
    assign Carry_Out    = cout_q;
    assign Overflow_Out = ovf_q;
    assign Zero_Out     = zero_q;
    assign Valid_Out    = vout_q;

endmodule

// File: tb/tb_pipelined_lookahead_adder.sv
module tb_pipelined_lookahead_adder;

    localparam int DW      = 32;
    localparam int BW      = 8;
    localparam int LATENCY = DW / BW;
    localparam int RW      = DW + 3;   // {sum, cout, ovf, zero}

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic          cin;
        logic          mode;
        logic [DW-1:0] sum;
        logic          cout;
        logic          ovf;
        logic          zero;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] data_a = '0;
    logic [DW-1:0] data_b = '0;
    logic          carry_in = 1'b0;
    logic          mode = 1'b0;
    logic          valid_in = 1'b0;
    logic          ready_out;
    logic [DW-1:0] sum_out;
    logic          carry_out;
    logic          overflow_out;
    logic          zero_out;
    logic          valid_out;
    logic          ready_in = 1'b1;

    logic [RW-1:0] exp_q[$];
    int            acc_q[$];
    bit            lat_q[$];
    bit            lat_chk = 1'b1;
    int            cyc = 0;
    int            checks = 0;
    int            errors = 0;

    pipelined_lookahead_adder #(
        .DATA_WIDTH  (DW),
        .BLOCK_WIDTH (BW)
    ) dut (
        .Clock_In     (clk),
        .Reset_In     (rst),
        .Data_A_In    (data_a),
        .Data_B_In    (data_b),
        .Carry_In     (carry_in),
        .Mode_In      (mode),
        .Valid_In     (valid_in),
        .Ready_Out    (ready_out),
        .Sum_Out      (sum_out),
        .Carry_Out    (carry_out),
        .Overflow_Out (overflow_out),
        .Zero_Out     (zero_out),
        .Valid_Out    (valid_out),
        .Ready_In     (ready_in)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic vec_t mk(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                input logic cin, input logic md, input logic [DW-1:0] s,
                                input logic co, input logic ov, input logic z);
        vec_t v;
        v.a = a; v.b = b; v.cin = cin; v.mode = md;
        v.sum = s; v.cout = co; v.ovf = ov; v.zero = z;
        return v;
    endfunction

    // Driver: present one operation, hold it until taken; push the expected
    // response at the cycle the handshake completes.
    task automatic send(input vec_t v);
        bit taken;
        taken    = 1'b0;
        data_a   = v.a;
        data_b   = v.b;
        carry_in = v.cin;
        mode     = v.mode;
        valid_in = 1'b1;
        for (int t = 0; t < 50 && !taken; t++) begin
            @(negedge clk);
            if (ready_out) begin
                taken = 1'b1;
                exp_q.push_back({v.sum, v.cout, v.ovf, v.zero});
                acc_q.push_back(cyc);
                lat_q.push_back(lat_chk);
            end
            @(posedge clk);
            #1;
        end
        if (!taken) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got not_accepted expected accepted");
        end
        valid_in = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_reset_state(input string tag);
        @(negedge clk);
        check({tag, "_valid_out"}, 64'(valid_out), 64'd0);
        check({tag, "_sum_out"}, 64'(sum_out), 64'd0);
        check({tag, "_carry_out"}, 64'(carry_out), 64'd0);
        check({tag, "_overflow_out"}, 64'(overflow_out), 64'd0);
        check({tag, "_zero_out"}, 64'(zero_out), 64'd0);
        check({tag, "_ready_out"}, 64'(ready_out), 64'd1);
    endtask

    // Scoreboard monitor: a result is consumed on any edge with Valid_Out & Ready_In.
    always @(negedge clk) begin
        if (!rst && valid_out && ready_in) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got sum=%0h expected no_result", sum_out);
            end else begin
                logic [RW-1:0] e;
                int            acc;
                bit            lc;
                e   = exp_q.pop_front();
                acc = acc_q.pop_front();
                lc  = lat_q.pop_front();
                check("result", 64'({sum_out, carry_out, overflow_out, zero_out}), 64'(e));
                if (lc) check("latency", 64'(cyc - acc), 64'(LATENCY));
            end
        end
    end

    initial begin
        vec_t dir[$];
        vec_t bb[$];
        vec_t st[$];
        vec_t fl[$];
        int   w;

        // Reset
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed vectors: {a, b, cin, mode, sum, cout, ovf, zero}
        dir.push_back(mk(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1));
        dir.push_back(mk(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0));
        dir.push_back(mk(32'h0000_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0));
        foreach (dir[i]) begin
            send(dir[i]);
            repeat (2) @(posedge clk);
            #1;
        end
        drain();

        // Back-to-back adds, consumer always ready
        bb.push_back(mk(32'd1, 32'd1, 1'b0, 1'b0, 32'd2, 1'b0, 1'b0, 1'b0));
        bb.push_back(mk(32'd2, 32'd2, 1'b0, 1'b0, 32'd4, 1'b0, 1'b0, 1'b0));
        bb.push_back(mk(32'd3, 32'd3, 1'b0, 1'b0, 32'd6, 1'b0, 1'b0, 1'b0));
        bb.push_back(mk(32'd4, 32'd4, 1'b0, 1'b0, 32'd8, 1'b0, 1'b0, 1'b0));
        bb.push_back(mk(32'd5, 32'd5, 1'b0, 1'b1, 32'd0, 1'b1, 1'b0, 1'b1));
        bb.push_back(mk(32'd0, 32'd1, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0));
        bb.push_back(mk(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0));
        bb.push_back(mk(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b1));
        bb.push_back(mk(32'hA, 32'd3, 1'b1, 1'b1, 32'd7, 1'b1, 1'b0, 1'b0));
        bb.push_back(mk(32'h1234_5678, 32'h8765_4321, 1'b0, 1'b0, 32'h9999_9999, 1'b0, 1'b0, 1'b0));
        bb.push_back(mk(32'h0000_00FF, 32'd1, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0));
        bb.push_back(mk(32'h00FF_FFFF, 32'd0, 1'b1, 1'b0, 32'h0100_0000, 1'b0, 1'b0, 1'b0));
        bb.push_back(mk(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0));
        foreach (bb[i]) send(bb[i]);
        drain();

        // Stall: hold the consumer off for 3 cycles with a full pipe and a
        // pending input; nothing may be taken and the head result must hold.
        lat_chk = 1'b0;
        st.push_back(mk(32'h10, 32'h01, 1'b0, 1'b0, 32'h11, 1'b0, 1'b0, 1'b0));
        st.push_back(mk(32'h20, 32'h02, 1'b0, 1'b0, 32'h22, 1'b0, 1'b0, 1'b0));
        st.push_back(mk(32'h30, 32'h03, 1'b0, 1'b0, 32'h33, 1'b0, 1'b0, 1'b0));
        st.push_back(mk(32'h40, 32'h04, 1'b0, 1'b0, 32'h44, 1'b0, 1'b0, 1'b0));
        st.push_back(mk(32'h50, 32'h05, 1'b0, 1'b0, 32'h55, 1'b0, 1'b0, 1'b0));
        for (int i = 0; i < 4; i++) send(st[i]);
        w = 0;
        while (!valid_out && w < 10) begin
            @(posedge clk);
            #1;
            w++;
        end
        check("stall_setup_valid", 64'(valid_out), 64'd1);
        fork
            send(st[4]);
            begin
                ready_in = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    check("stall_ready_out", 64'(ready_out), 64'd0);
                    check("stall_valid_out", 64'(valid_out), 64'd1);
                    check("stall_head_held", 64'({sum_out, carry_out, overflow_out, zero_out}),
                          64'(exp_q[0]));
                    check("stall_no_accept", 64'(exp_q.size()), 64'd4);
                    @(posedge clk);
                    #1;
                end
                ready_in = 1'b1;
            end
        join
        drain();
        lat_chk = 1'b1;

        // Reset with three operations in flight; none may survive.
        fl.push_back(mk(32'h100, 32'h200, 1'b0, 1'b0, 32'h300, 1'b0, 1'b0, 1'b0));
        fl.push_back(mk(32'd9, 32'd4, 1'b0, 1'b1, 32'd5, 1'b1, 1'b0, 1'b0));
        fl.push_back(mk(32'd7, 32'd7, 1'b0, 1'b1, 32'd0, 1'b1, 1'b0, 1'b1));
        foreach (fl[i]) send(fl[i]);
        rst = 1'b1;
        exp_q.delete();
        acc_q.delete();
        lat_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_state("flush");
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("flush_no_stale", 64'(valid_out), 64'd0);
        end

        // Pipeline still works after the flush
        @(posedge clk);
        #1;
        send(mk(32'hA, 32'hB, 1'b0, 1'b0, 32'h15, 1'b0, 1'b0, 1'b0));
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
